// File: rtl/imem_pkg.sv
`default_nettype none
// =============================================================================
// Module      : imem_pkg
// Description : Shared state encoding, fault codes and parameter checks for
//               the synchronous instruction memory.
// Revision    : 1.0 - initial release
// =============================================================================
package imem_pkg;

  localparam logic [0:0]  ST_CLEAR         = 1'b0;
  localparam logic [0:0]  ST_READY         = 1'b1;

  localparam logic [1:0]  FAULT_MISALIGN   = 2'b01;
  localparam logic [1:0]  FAULT_RANGE      = 2'b10;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  function automatic bit latency_ok(input int lat);
    return (lat >= 1) && (lat <= 3);
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_fetch_pipe.sv
`default_nettype none
// =============================================================================
// Module      : imem_fetch_pipe
// Description : LATENCY-deep valid/instr/fault shift register with a common
//               stall enable; payload only moves alongside a valid bit.
// Revision    : 1.0 - initial release
// =============================================================================
module imem_fetch_pipe
  import imem_pkg::*;
#(
  parameter int          LATENCY  = 1,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  input  logic [1:0]  in_fault,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [1:0]  out_fault
);

  logic [LATENCY-1:0] r_valid;
  logic [31:0]        r_instr [LATENCY];
  logic [1:0]         r_fault [LATENCY];

  // A stage keeps its last payload when a bubble passes, so the output
  // holds the most recent result while fetch_valid is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        r_instr[k] <= NOP_WORD;
        r_fault[k] <= 2'b00;
      end
    end else if (!stall) begin
      r_valid[0] <= in_valid;
      if (in_valid) begin
        r_instr[0] <= in_instr;
        r_fault[0] <= in_fault;
      end
      for (int k = 1; k < LATENCY; k++) begin
        r_valid[k] <= r_valid[k-1];
        if (r_valid[k-1]) begin
          r_instr[k] <= r_instr[k-1];
          r_fault[k] <= r_fault[k-1];
        end
      end
    end
  end

  assign out_valid = r_valid[LATENCY-1];
  assign out_instr = r_instr[LATENCY-1];
  assign out_fault = r_fault[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/imem_sync_loader.sv
`default_nettype none
// =============================================================================
// Module      : imem_sync_loader
// Description : Byte-addressed, big-endian synchronous instruction memory
//               with run-time byte loader, zero-fill after reset and faults.
// Revision    : 1.0 - initial release
// =============================================================================
module imem_sync_loader
  import imem_pkg::*;
#(
  parameter int          ADDR_W   = 14,
  parameter int          LATENCY  = 1,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  input  logic              stall,
  output logic              fetch_rdy,
  output logic              fetch_valid,
  output logic [31:0]       instr,
  output logic [1:0]        fault,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              load_rdy
);

  localparam int              c_DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-3:0] c_LAST_WORD = '1;

  if (!latency_ok(LATENCY)) begin : g_bad_latency
    $error("imem_sync_loader: LATENCY must be in 1..3");
  end

  logic [7:0]        r_mem [c_DEPTH];
  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  // Clear pointer counts words; the byte address is {r_clr_ptr, 2'b00}.
  logic [ADDR_W-3:0] r_clr_ptr;
  logic              w_rdy;
  logic              w_clr_we;
  logic              w_load_we;
  logic              w_accept;
  logic [1:0]        w_fault;
  logic [ADDR_W-3:0] w_word;
  logic [31:0]       w_rdata;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: if (r_clr_ptr == c_LAST_WORD) w_state_nxt = ST_READY;
      ST_READY: w_state_nxt = ST_READY;
      default:  w_state_nxt = ST_CLEAR;
    endcase
  end

  // State outputs
  always_comb begin
    w_rdy    = 1'b0;
    w_clr_we = 1'b0;
    case (r_state)
      ST_CLEAR: w_clr_we = 1'b1;
      ST_READY: w_rdy    = 1'b1;
      default:  w_clr_we = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clr_ptr <= '0;
    end else if (w_clr_we) begin
      r_clr_ptr <= r_clr_ptr + 1'b1;
    end
  end

  assign w_load_we = load_en && w_rdy && !reset;

  // Non-blocking writes give read-before-write against a same-cycle fetch.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[{r_clr_ptr, 2'b00}] <= 8'h00;
      r_mem[{r_clr_ptr, 2'b01}] <= 8'h00;
      r_mem[{r_clr_ptr, 2'b10}] <= 8'h00;
      r_mem[{r_clr_ptr, 2'b11}] <= 8'h00;
    end else if (w_load_we) begin
      r_mem[load_addr] <= load_data;
    end
  end

  assign w_fault  = ((|fetch_addr[1:0])      ? FAULT_MISALIGN : 2'b00)
                  | ((|fetch_addr[31:ADDR_W]) ? FAULT_RANGE    : 2'b00);
  assign w_accept = fetch_req && w_rdy && !stall;
  assign w_word   = fetch_addr[ADDR_W-1:2];

  always_comb begin
    w_rdata = NOP_WORD;
    if (w_fault == 2'b00) begin
      w_rdata = {r_mem[{w_word, 2'b00}], r_mem[{w_word, 2'b01}],
                 r_mem[{w_word, 2'b10}], r_mem[{w_word, 2'b11}]};
    end
  end

  imem_fetch_pipe #(
    .LATENCY  (LATENCY),
    .NOP_WORD (NOP_WORD)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .in_valid  (w_accept),
    .in_instr  (w_rdata),
    .in_fault  (w_fault),
    .out_valid (fetch_valid),
    .out_instr (instr),
    .out_fault (fault)
  );

  assign fetch_rdy = w_rdy;
  assign load_rdy  = w_rdy;

endmodule
`default_nettype wire

// File: tb/tb_imem_sync_loader.sv
`default_nettype none
// =============================================================================
// Module      : tb_imem_sync_loader
// Description : Self-checking bench: vector table plus scoreboard of fetch
//               results, with hand sequences for stall, collision and reset.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_imem_sync_loader;

  localparam int          ADDR_W  = 14;
  localparam int          LATENCY = 2;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic              clk;
  logic              reset;
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic              stall;
  logic              fetch_rdy;
  logic              fetch_valid;
  logic [31:0]       instr;
  logic [1:0]        fault;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        load_data;
  logic              load_rdy;

  imem_sync_loader #(
    .ADDR_W   (ADDR_W),
    .LATENCY  (LATENCY),
    .NOP_WORD (NOP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .stall       (stall),
    .fetch_rdy   (fetch_rdy),
    .fetch_valid (fetch_valid),
    .instr       (instr),
    .fault       (fault),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_rdy    (load_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  fault;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_instr;
    logic [1:0]  exp_fault;
  } vec_t;

  exp_t        sbq[$];
  vec_t        vecs[8];
  int          n_checks = 0;
  int          n_pass   = 0;

  logic        m_adv;
  logic        m_rst;
  logic        p_valid;
  logic [31:0] p_instr;
  logic [1:0]  p_fault;
  exp_t        m_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Output monitor: pops the scoreboard on advancing edges, checks hold on stalls.
  always begin
    @(posedge clk);
    m_adv = !stall && !reset;
    m_rst = reset;
    #1;
    if (!m_rst) begin
      if (m_adv) begin
        if (fetch_valid) begin
          if (sbq.size() == 0) begin
            chk("unexpected_valid", {31'b0, fetch_valid}, 32'd0);
          end else begin
            m_e = sbq.pop_front();
            chk("instr", instr, m_e.instr);
            chk("fault", {30'b0, fault}, {30'b0, m_e.fault});
          end
        end
      end else begin
        chk("stall_hold_valid", {31'b0, fetch_valid}, {31'b0, p_valid});
        chk("stall_hold_instr", instr, p_instr);
        chk("stall_hold_fault", {30'b0, fault}, {30'b0, p_fault});
      end
    end
    p_valid = fetch_valid;
    p_instr = instr;
    p_fault = fault;
  end

  // All driver tasks start and end at a falling edge.
  task automatic fetch(input logic [31:0] a, input logic st,
                       input logic [31:0] ei, input logic [1:0] ef);
    fetch_req  = 1'b1;
    fetch_addr = a;
    stall      = st;
    if (fetch_rdy && !st) sbq.push_back('{ei, ef});
    @(negedge clk);
    fetch_req = 1'b0;
    stall     = 1'b0;
  endtask

  task automatic idle(input int n);
    fetch_req = 1'b0;
    stall     = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic drain(input string name);
    idle(LATENCY + 2);
    chk(name, 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    fetch_req = 1'b0;
    load_en   = 1'b0;
    stall     = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_valid",    {31'b0, fetch_valid}, 32'd0);
    chk("rst_instr",    instr, NOP);
    chk("rst_fault",    {30'b0, fault}, 32'd0);
    chk("rst_fetch_rdy", {31'b0, fetch_rdy}, 32'd0);
    chk("rst_load_rdy", {31'b0, load_rdy}, 32'd0);
    sbq.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Counts not-ready samples from reset release; optionally pokes ignored ports.
  task automatic wait_clear(input string name, input bit poke);
    int cnt;
    cnt = 0;
    while (!fetch_rdy && cnt < 5000) begin
      if (poke && cnt < 100) begin
        fetch_req  = 1'b1;
        fetch_addr = 32'h10;
        load_en    = 1'b1;
        load_addr  = 14'h10;
        load_data  = 8'h5A;
      end else begin
        fetch_req = 1'b0;
        load_en   = 1'b0;
      end
      cnt++;
      @(posedge clk);
      #1;
    end
    chk(name, 32'(cnt), 32'd4096);
    @(negedge clk);
  endtask

  initial begin
    reset      = 1'b1;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    stall      = 1'b0;
    load_en    = 1'b0;
    load_addr  = '0;
    load_data  = '0;

    vecs[0] = '{32'h0000_0064, 32'h4808_0000, 2'b00};
    vecs[1] = '{32'h0000_0066, NOP,           2'b01};
    vecs[2] = '{32'h0000_4000, NOP,           2'b10};
    vecs[3] = '{32'h0000_4002, NOP,           2'b11};
    vecs[4] = '{32'h0000_3FFC, 32'hAABB_CCDD, 2'b00};
    vecs[5] = '{32'h0000_0010, 32'h0000_0000, 2'b00};
    vecs[6] = '{32'h8000_0000, NOP,           2'b10};
    vecs[7] = '{32'hFFFF_FFFF, NOP,           2'b11};

    @(negedge clk);
    @(negedge clk);
    do_reset();
    wait_clear("clear_len", 1'b1);

    fetch(32'h0, 1'b0, 32'h0000_0000, 2'b00);
    drain("sb_empty_first");

    load(14'h64, 8'h48); load(14'h65, 8'h08); load(14'h66, 8'h00); load(14'h67, 8'h00);
    load(14'h69, 8'h11); load(14'h6A, 8'h22); load(14'h6B, 8'h33);
    load(14'h6C, 8'h01); load(14'h6D, 8'h02); load(14'h6E, 8'h03); load(14'h6F, 8'h04);
    load(14'h3FFC, 8'hAA); load(14'h3FFD, 8'hBB); load(14'h3FFE, 8'hCC); load(14'h3FFF, 8'hDD);

    // Latency: valid must stay low one edge after acceptance, then rise.
    fetch_req  = 1'b1;
    fetch_addr = 32'h64;
    sbq.push_back('{32'h4808_0000, 2'b00});
    @(posedge clk);
    #1;
    fetch_req = 1'b0;
    chk("lat_edge1_valid", {31'b0, fetch_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("lat_edge2_valid", {31'b0, fetch_valid}, 32'd1);
    @(negedge clk);
    drain("sb_empty_latency");

    for (int i = 0; i < 8; i++) begin
      fetch(vecs[i].addr, 1'b0, vecs[i].exp_instr, vecs[i].exp_fault);
    end
    drain("sb_empty_table");

    fetch(32'h64, 1'b0, 32'h4808_0000, 2'b00);
    fetch(32'h68, 1'b0, 32'h0011_2233, 2'b00);
    fetch(32'h6C, 1'b1, 32'h0102_0304, 2'b00);
    fetch(32'h6C, 1'b1, 32'h0102_0304, 2'b00);
    fetch(32'h6C, 1'b1, 32'h0102_0304, 2'b00);
    fetch(32'h6C, 1'b0, 32'h0102_0304, 2'b00);
    drain("sb_empty_stall");

    load_en   = 1'b1;
    load_addr = 14'h68;
    load_data = 8'hFF;
    fetch(32'h68, 1'b0, 32'h0011_2233, 2'b00);
    load_en = 1'b0;
    fetch(32'h68, 1'b0, 32'hFF11_2233, 2'b00);
    drain("sb_empty_collision");

    fetch(32'h64, 1'b0, 32'h4808_0000, 2'b00);
    fetch(32'h6C, 1'b0, 32'h0102_0304, 2'b00);
    do_reset();
    idle(1000);
    do_reset();
    wait_clear("clear_len_restart", 1'b0);

    fetch(32'h64, 1'b0, 32'h0000_0000, 2'b00);
    fetch(32'h68, 1'b0, 32'h0000_0000, 2'b00);
    fetch(32'h3FFC, 1'b0, 32'h0000_0000, 2'b00);
    drain("sb_empty_final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/imem_sync_loader.md
Name: imem_sync_loader

Overview:
- Synchronous, parametrised instruction memory replacing the combinational, initial-block-loaded instruction store used by the current single-cycle datapath.
- Byte-addressed, big-endian word assembly; loaded at run time through a byte loader port, so test programs no longer live in the RTL.
- Zero-fills itself after reset and returns fetches over a fixed-latency, stallable pipeline with alignment and range fault flags.
- Sits between the IF-stage PC register and the IF/ID pipeline register.

Parameters:
- ADDR_W, 14, byte-address width of the array; depth = 2**ADDR_W bytes (default 16 KB).
- LATENCY, 1, fetch-to-data latency in cycles; legal range 1..3.
- NOP_WORD, 32'h0000_0000, word returned on a faulted fetch.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_req  in  1  fetch request; accepted when fetch_rdy=1 and stall=0.
- fetch_addr  in  32  byte address (PC) of the requested instruction.
- stall  in  1  freezes the fetch pipeline and holds all fetch outputs.
- fetch_rdy  out  1  1 when the memory is in READY state.
- fetch_valid  out  1  instr/fault are valid for the oldest accepted request.
- instr  out  32  {mem[a],mem[a+1],mem[a+2],mem[a+3]}, big-endian.
- fault  out  2  bit0 = misaligned (a[1:0]!=0); bit1 = out of range (a[31:ADDR_W]!=0).
- load_en  in  1  byte write strobe.
- load_addr  in  ADDR_W  byte write address.
- load_data  in  8  byte to write.
- load_rdy  out  1  equals fetch_rdy; writes are dropped when it is 0.

Behaviour:
- Reset values: fetch_rdy=0, load_rdy=0, fetch_valid=0, instr=NOP_WORD, fault=0. All fetch pipeline stages are invalidated. The state machine enters CLEAR with clr_ptr=0.
- CLEAR state:
  - Writes one zeroed 32-bit word (4 bytes) per cycle at clr_ptr, then clr_ptr += 4.
  - Leaves for READY on the cycle the last word (2**ADDR_W-4) is written, so CLEAR lasts 2**ADDR_W/4 cycles (4096 at default).
  - fetch_req and load_en are ignored while in CLEAR.
- READY state:
  - Remains in READY until reset.
  - reset asserted in any state, including mid-CLEAR or with fetches in flight, restarts CLEAR from 0 and flushes the pipeline.
- Fetch acceptance and latency:
  - A request is accepted when fetch_req && fetch_rdy && !stall.
  - Its result appears with fetch_valid=1 exactly LATENCY un-stalled cycles later.
  - One request per cycle is allowed; throughput is 1 per cycle.
- Stall:
  - While stall=1, no stage advances and no request is accepted.
  - fetch_valid, instr and fault hold their values; an in-flight request is neither lost nor duplicated.
- Array read timing: the array is read in the acceptance cycle. Later stages only carry the data.
- Faults:
  - If either fault bit is set, instr=NOP_WORD and the array is not read.
  - Both fault bits may be set together (2'b11).
  - The range check uses the full 32-bit address; there is no wrap-around.
- Read/write collision: a load write and a fetch of the same word in the same cycle return the OLD data (read-before-write). The new byte is visible to the next accepted fetch.
- Word boundary: an aligned in-range fetch at 2**ADDR_W-4 reads the last 4 bytes and never indexes past the array.
- Idle output: when fetch_valid=0, instr and fault hold their last values; consumers must qualify them with fetch_valid.

Decomposition:
- Package imem_pkg holds:
  - state encoding {CLEAR, READY};
  - FAULT_MISALIGN = 2'b01 and FAULT_RANGE = 2'b10;
  - NOP_WORD default;
  - the LATENCY legality check.
- Sub-module imem_fetch_pipe: a LATENCY-deep valid/data/fault shift register with a common stall enable, instantiated once.
- The byte array, the CLEAR state machine and the loader write logic remain in the top module.

Test Plan:
- Reset, then wait -> fetch_rdy=0 for exactly 4096 cycles, then 1; fetch of 0x0 returns instr=0x00000000, fault=0.
- Load bytes 48 08 00 00 at 0x64..0x67, then fetch 0x64 with LATENCY=2 -> fetch_valid rises 2 cycles after acceptance; instr=0x48080000, fault=0.
- Fetch 0x66 -> fault=2'b01, instr=NOP. Fetch 0x0000_4000 -> fault=2'b10. Fetch 0x0000_4002 -> fault=2'b11.
- Back-to-back fetches of 0x64, 0x68, 0x6C with stall=1 held for 3 cycles mid-stream -> three valid results in order; outputs frozen during the stall; no drop, no duplicate.
- In the same cycle, load_en writes 0xFF to 0x68 and fetch 0x68 is accepted -> old word returned; the next fetch of 0x68 returns 0xFF in byte 0.
- reset pulsed mid-CLEAR and again with 2 fetches in flight -> fetch_valid=0 the next cycle; CLEAR restarts and takes the full 4096 cycles; previously loaded bytes read back as 0.
